dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_pkg.sv | 18 +
 rtl/dcache_array.sv | 49 ++++
 rtl/dcache_ctrl.sv | 135 +++++++++++++
 tb/tb_dcache_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data cache controller.
// Bus field positions for the memory-stage request/response buses.
package dcache_ctrl_pkg;

  localparam int DC_W = 32;

  localparam int DCBUS_RD       = 2*DC_W + 1;
  localparam int DCBUS_WR       = 2*DC_W;
  localparam int DCBUS_ADDR_HI  = 2*DC_W - 1;
  localparam int DCBUS_ADDR_LO  = DC_W;
  localparam int DCBUS_WDATA_HI = DC_W - 1;
  localparam int DCBUS_WDATA_LO = 0;

  localparam int DCBUS_MISS     = DC_W;
  localparam int DCBUS_RDATA_HI = DC_W - 1;
  localparam int DCBUS_RDATA_LO = 0;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped one-word-line cache.
// Combinational read port, synchronous write port, sync valid clear.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 24,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [WIDTH-1:0]      rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [WIDTH-1:0]      wr_data_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [WIDTH-1:0] data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Valid bits: cleared on reset, set by any line write.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through no-write-allocate data cache controller.
// Reads hit in zero cycles; misses and all writes go to backing memory.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int WIDTH      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH+1:0] Dcache_bus_in,
  output logic [WIDTH:0]     Dcache_bus_out,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ack
);

  localparam int TAG_W = WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                  rd, wr;
  logic [WIDTH-1:0]      addr, wdata;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  line_v;
  logic [TAG_W-1:0]      line_tag;
  logic [WIDTH-1:0]      line_data;
  logic                  hit;
  logic                  arr_we;
  logic [WIDTH-1:0]      arr_wdata;
  logic                  miss;
  logic [WIDTH-1:0]      rdata;

  assign rd    = Dcache_bus_in[DCBUS_RD];
  assign wr    = Dcache_bus_in[DCBUS_WR];
  assign addr  = Dcache_bus_in[DCBUS_ADDR_HI:DCBUS_ADDR_LO];
  assign wdata = Dcache_bus_in[DCBUS_WDATA_HI:DCBUS_WDATA_LO];
  assign idx   = addr[INDEX_BITS+1:2];
  assign tag   = addr[WIDTH-1:INDEX_BITS+2];
  assign hit   = line_v && (line_tag == tag);

  assign Dcache_bus_out[DCBUS_MISS] = miss;
  assign Dcache_bus_out[DCBUS_RDATA_HI:DCBUS_RDATA_LO] = rdata;

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .WIDTH      (WIDTH)
  ) u_array (
    .clk        (clk),
    .rst_n_i    (rst),
    .rd_idx_i   (idx),
    .rd_valid_o (line_v),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_i       (arr_we),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (arr_wdata)
  );

  // State register; reset abandons any outstanding memory transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stage response, memory request and line update.
  always_comb begin
    state_d   = state_q;
    miss      = 1'b0;
    rdata     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    arr_we    = 1'b0;
    arr_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (wr) begin
          miss    = 1'b1;
          state_d = WRITE;
        end else if (rd) begin
          if (hit) begin
            rdata = line_data;
          end else begin
            miss    = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = addr & ~{{(WIDTH-2){1'b0}}, 2'b11};
        miss     = 1'b1;
        if (mem_ack) begin
          miss      = 1'b0;
          rdata     = mem_rdata;
          arr_we    = rst;
          arr_wdata = mem_rdata;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr & ~{{(WIDTH-2){1'b0}}, 2'b11};
        mem_wdata = wdata;
        miss      = 1'b1;
        if (mem_ack) begin
          miss      = 1'b0;
          arr_we    = rst && hit;
          arr_wdata = wdata;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed table-driven bench for dcache_ctrl.
// Each row is one clock cycle of stimulus and expected outputs.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [65:0] bus_in = '0;
  logic [32:0] bus_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .Dcache_bus_in  (bus_in),
    .Dcache_bus_out (bus_out),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  typedef struct {
    logic        rstn;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] mrd;
    logic        miss;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rstn, input logic rd, input logic wr,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic ack, input logic [31:0] mrd,
    input logic miss, input logic [31:0] rdata,
    input logic req, input logic we,
    input logic [31:0] maddr, input logic [31:0] mwd);
    vec_t v;
    v.rstn = rstn; v.rd = rd; v.wr = wr;
    v.addr = addr; v.wdata = wdata;
    v.ack = ack; v.mrd = mrd;
    v.miss = miss; v.rdata = rdata;
    v.req = req; v.we = we;
    v.maddr = maddr; v.mwd = mwd;
    return v;
  endfunction

  task automatic drive(input logic rstn, input logic rd,
                       input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ack,
                       input logic [31:0] mrd);
    rst = rstn;
    bus_in = '0;
    bus_in[DCBUS_RD] = rd;
    bus_in[DCBUS_WR] = wr;
    bus_in[DCBUS_ADDR_HI:DCBUS_ADDR_LO] = addr;
    bus_in[DCBUS_WDATA_HI:DCBUS_WDATA_LO] = wdata;
    mem_ack = ack;
    mem_rdata = mrd;
  endtask

  task automatic check(input string name, input vec_t e);
    logic [130:0] act, exp;
    act = {bus_out[32], bus_out[31:0], mem_req, mem_we,
           mem_addr, mem_wdata};
    exp = {e.miss, e.rdata, e.req, e.we, e.maddr, e.mwd};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got miss=%b rdata=%h req=%b we=%b addr=%h wd=%h want miss=%b rdata=%h req=%b we=%b addr=%h wd=%h",
               name, bus_out[32], bus_out[31:0], mem_req, mem_we,
               mem_addr, mem_wdata, e.miss, e.rdata, e.req, e.we,
               e.maddr, e.mwd);
    end
  endtask

  initial begin
    // rstn rd wr addr wdata ack mrd | miss rdata req we maddr mwd
    // reset and idle
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0));
    // cold read 0x104, ack after 3 fill cycles
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 1,0,1,0,'h104,0));
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 1,0,1,0,'h104,0));
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 1,0,1,0,'h104,0));
    tbl.push_back(mk(1,1,0,'h104,0,1,'hDEADBEEF,
                     0,'hDEADBEEF,1,0,'h104,0));
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 0,'hDEADBEEF,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h107,0,0,0, 0,'hDEADBEEF,0,0,0,0));
    // write hit 0x104
    tbl.push_back(mk(1,0,1,'h104,'h12345678,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,'h104,'h12345678,0,0,
                     1,0,1,1,'h104,'h12345678));
    tbl.push_back(mk(1,0,1,'h104,'h12345678,1,0,
                     0,0,1,1,'h104,'h12345678));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 0,'h12345678,0,0,0,0));
    // conflict 0x504 vs 0x104
    tbl.push_back(mk(1,1,0,'h504,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h504,0,1,'hCAFEF00D,
                     0,'hCAFEF00D,1,0,'h504,0));
    tbl.push_back(mk(1,1,0,'h504,0,0,0, 0,'hCAFEF00D,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h104,0,1,'h11111111,
                     0,'h11111111,1,0,'h104,0));
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 0,'h11111111,0,0,0,0));
    // write miss 0x208, no allocate
    tbl.push_back(mk(1,0,1,'h208,'hAAAA5555,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,'h208,'hAAAA5555,1,0,
                     0,0,1,1,'h208,'hAAAA5555));
    tbl.push_back(mk(1,1,0,'h208,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h208,0,1,'h2, 0,'h2,1,0,'h208,0));
    // ack in idle ignored
    tbl.push_back(mk(1,0,0,0,0,1,'hFFFFFFFF, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h208,0,0,0, 0,'h2,0,0,0,0));
    // rd and wr together: treated as write
    tbl.push_back(mk(1,1,1,'h10,'h77,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,'h10,'h77,0,0, 1,0,1,1,'h10,'h77));
    tbl.push_back(mk(1,1,1,'h10,'h77,1,0, 0,0,1,1,'h10,'h77));
    tbl.push_back(mk(1,1,0,'h10,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h10,0,1,'h77, 0,'h77,1,0,'h10,0));
    // reset mid-fill
    tbl.push_back(mk(1,1,0,'h30C,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h30C,0,0,0, 1,0,1,0,'h30C,0));
    tbl.push_back(mk(0,1,0,'h30C,0,0,0, 1,0,1,0,'h30C,0));
    tbl.push_back(mk(1,0,0,0,0,1,'h99, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h104,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h104,0,1,'h5, 0,'h5,1,0,'h104,0));
    tbl.push_back(mk(1,1,0,'h30C,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h30C,0,1,'h9, 0,'h9,1,0,'h30C,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rstn, tbl[i].rd, tbl[i].wr, tbl[i].addr,
            tbl[i].wdata, tbl[i].ack, tbl[i].mrd);
      #4;
      check($sformatf("row%0d", i), tbl[i]);
    end

    // Write re-presented twice with a 2-cycle memory latency,
    // then a read of the line must return the written word.
    for (int rep = 0; rep < 2; rep++) begin
      int cyc;
      int req_cyc;
      bit done;
      cyc = 0;
      req_cyc = 0;
      done = 0;
      while (!done && cyc < 20) begin
        @(negedge clk);
        drive(1, 0, 1, 'h104, 'hBEEF0001, req_cyc == 2, 0);
        #4;
        if (mem_req) req_cyc++;
        if (!bus_out[32]) done = 1;
        cyc++;
      end
      checks++;
      if (!done || !mem_we || mem_wdata !== 32'hBEEF0001) begin
        errors++;
        $display("FAIL rewrite%0d: done=%0d we=%b wd=%h want done=1 we=1 wd=beef0001",
                 rep, done, mem_we, mem_wdata);
      end
    end
    @(negedge clk);
    drive(1, 1, 0, 'h104, 0, 0, 0);
    #4;
    check("rewrite_hit",
          mk(1,1,0,'h104,0,0,0, 0,'hBEEF0001,0,0,0,0));
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
